// File: rtl/medidor_frequencia.sv
// medidor_frequencia: counts rising edges of an asynchronous slow signal over
// back-to-back gate windows of GATE_CYCLES clock_50 cycles. It publishes each
// completed window's count in `frequencia`, together with a one-cycle
// `valido` strobe and the `estouro`/`sem_sinal` flags.
module medidor_frequencia #(
   parameter int GATE_CYCLES = 50000000,
   parameter int WIDTH       = 26
) (
   input  logic             clock_50,
   input  logic             reset,
   input  logic             habilita,
   input  logic             sinal_in,
   output logic [WIDTH-1:0] frequencia,
   output logic             valido,
   output logic             estouro,
   output logic             sem_sinal
);

   // The gate counter only has to reach GATE_CYCLES-1, so its width does not
   // depend on WIDTH.
   localparam int              GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic {
      PARADO = 1'b0,
      JANELA = 1'b1
   } estado_t;

   // Synchroniser (s1, s2) and edge-history (s3) flops.
   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;

   // Measurement state.
   estado_t          estado_q, estado_d;
   logic [GW-1:0]    gate_q, gate_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   // Published result, all registered.
   logic [WIDTH-1:0] freq_q, freq_d;
   logic             valido_q, valido_d;
   logic             estouro_q, estouro_d;
   logic             sem_q, sem_d;

   // Helper terms for the current cycle.
   logic             pulso;
   logic             cnt_cheio;
   logic [WIDTH-1:0] cnt_inc;
   logic             sat_inc;

   // Next-state logic: the synchroniser, window bookkeeping and result loading.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path through
      // this block leaves a value unassigned and no latch is inferred.
      s1_d      = sinal_in;
      s2_d      = s1_q;
      s3_d      = s2_q;
      estado_d  = estado_q;
      gate_d    = gate_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      freq_d    = freq_q;
      valido_d  = 1'b0;
      estouro_d = estouro_q;
      sem_d     = sem_q;

      // A rising edge is seen when s2 is high for the first cycle.
      pulso     = s2_q & ~s3_q;
      cnt_cheio = (cnt_q == CNT_MAX);
      cnt_inc   = (pulso && !cnt_cheio) ? cnt_q + 1'b1 : cnt_q;
      sat_inc   = sat_q | (pulso & cnt_cheio);

      case (estado_q)
         PARADO: begin
            gate_d = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
            if (habilita) estado_d = JANELA;
         end
         JANELA: begin
            if (!habilita) begin
               // An abort discards the window, even when it lands on the
               // final cycle.
               estado_d = PARADO;
               gate_d   = '0;
               cnt_d    = '0;
               sat_d    = 1'b0;
            end else if (gate_q == GATE_LAST) begin
               // Final cycle. An edge arriving in this cycle still counts, and
               // the next window starts with no gap.
               freq_d    = cnt_inc;
               estouro_d = sat_inc;
               sem_d     = (cnt_inc == '0);
               valido_d  = 1'b1;
               gate_d    = '0;
               cnt_d     = '0;
               sat_d     = 1'b0;
            end else begin
               gate_d = gate_q + 1'b1;
               cnt_d  = cnt_inc;
               sat_d  = sat_inc;
            end
         end
         default: estado_d = PARADO;
      endcase
   end

   // State register. The synchronous reset wins over everything, including
   // window completion in the same cycle.
   always_ff @(posedge clock_50) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values from before this edge.
      if (!reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         estado_q  <= PARADO;
         gate_q    <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         freq_q    <= '0;
         valido_q  <= 1'b0;
         estouro_q <= 1'b0;
         sem_q     <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         estado_q  <= estado_d;
         gate_q    <= gate_d;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         freq_q    <= freq_d;
         valido_q  <= valido_d;
         estouro_q <= estouro_d;
         sem_q     <= sem_d;
      end
   end

   assign frequencia = freq_q;
   assign valido     = valido_q;
   assign estouro    = estouro_q;
   assign sem_sinal  = sem_q;

endmodule

// File: tb/tb_medidor_frequencia.sv
// Bench for medidor_frequencia. Two instances share all of their inputs and
// use 100-cycle windows. The WIDTH=8 instance never saturates. The WIDTH=4
// instance saturates once a window holds more than 15 edges.
module tb_medidor_frequencia;

   localparam int G = 100;

   logic       clock_50 = 1'b0;
   logic       reset;
   logic       habilita;
   logic       sinal_in;
   logic [7:0] freq_a;
   logic [3:0] freq_b;
   logic       va, vb, ea, eb, sa, sb;

   int checks = 0;
   int erros  = 0;
   int periodo = 0;
   int fase    = 0;

   medidor_frequencia #(.GATE_CYCLES(G), .WIDTH(8)) dut_a (
      .clock_50  (clock_50),
      .reset     (reset),
      .habilita  (habilita),
      .sinal_in  (sinal_in),
      .frequencia(freq_a),
      .valido    (va),
      .estouro   (ea),
      .sem_sinal (sa)
   );

   medidor_frequencia #(.GATE_CYCLES(G), .WIDTH(4)) dut_b (
      .clock_50  (clock_50),
      .reset     (reset),
      .habilita  (habilita),
      .sinal_in  (sinal_in),
      .frequencia(freq_b),
      .valido    (vb),
      .estouro   (eb),
      .sem_sinal (sb)
   );

   always #10 clock_50 = ~clock_50;

   // Square-wave source, updated on the falling edge: high for periodo/2
   // cycles, then low; held at 0 when periodo is 0.
   initial begin
      sinal_in = 1'b0;
      forever begin
         @(negedge clock_50);
         if (periodo == 0) begin
            fase     = 0;
            sinal_in = 1'b0;
         end else begin
            sinal_in = (fase < periodo / 2);
            fase     = (fase + 1 >= periodo) ? 0 : fase + 1;
         end
      end
   end

   // Safety net in case the bench itself stalls.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nome, input int atual, input int esperado);
      checks++;
      if (atual !== esperado) begin
         erros++;
         $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
      end
   endtask

   task automatic tick();
      @(posedge clock_50);
      #1;
   endtask

   task automatic check_saidas(input string tag, input int fa, input int fb,
                               input int exp_ea, input int exp_eb,
                               input int exp_sem, input int exp_val);
      check({tag, ".freq_a"},  int'(freq_a), fa);
      check({tag, ".freq_b"},  int'(freq_b), fb);
      check({tag, ".estouro_a"}, int'(ea), exp_ea);
      check({tag, ".estouro_b"}, int'(eb), exp_eb);
      check({tag, ".sem_a"},   int'(sa), exp_sem);
      check({tag, ".sem_b"},   int'(sb), exp_sem);
      check({tag, ".valido_a"}, int'(va), exp_val);
      check({tag, ".valido_b"}, int'(vb), exp_val);
   endtask

   // Counts clock edges until valido is seen, within a bounded budget.
   task automatic esperar_valido(input string nome, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!va && n < 3 * G);
      check({nome, ".valido_timeout"}, int'(va), 1);
   endtask

   typedef struct {
      int   periodo;
      int   freq_a;
      int   freq_b;
      logic est_a;
      logic est_b;
      logic sem;
   } vetor_t;

   vetor_t tab[6];

   initial begin
      int n;
      int pulsos;

      tab[0] = '{periodo: 0,  freq_a: 0,  freq_b: 0,  est_a: 1'b0, est_b: 1'b0, sem: 1'b1};
      tab[1] = '{periodo: 4,  freq_a: 25, freq_b: 15, est_a: 1'b0, est_b: 1'b1, sem: 1'b0};
      tab[2] = '{periodo: 10, freq_a: 10, freq_b: 10, est_a: 1'b0, est_b: 1'b0, sem: 1'b0};
      tab[3] = '{periodo: 25, freq_a: 4,  freq_b: 4,  est_a: 1'b0, est_b: 1'b0, sem: 1'b0};
      tab[4] = '{periodo: 4,  freq_a: 25, freq_b: 15, est_a: 1'b0, est_b: 1'b1, sem: 1'b0};
      tab[5] = '{periodo: 0,  freq_a: 0,  freq_b: 0,  est_a: 1'b0, est_b: 1'b0, sem: 1'b1};

      // Reset is held with habilita=1 and the input toggling; nothing may
      // come out while reset is low or just after it is released.
      reset    = 1'b0;
      habilita = 1'b1;
      periodo  = 4;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_saidas($sformatf("reset%0d", i), 0, 0, 0, 0, 0, 0);
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_saidas($sformatf("pos_reset%0d", i), 0, 0, 0, 0, 0, 0);
      end
      habilita = 1'b0;
      periodo  = 10;
      repeat (20) tick();

      // The first result arrives 101 edges after habilita is sampled, and
      // later results follow every 100 edges.
      habilita = 1'b1;
      esperar_valido("janela1", n);
      check("janela1.latencia", n, G + 1);
      check_saidas("janela1", 10, 10, 0, 0, 0, 1);
      esperar_valido("janela2", n);
      check("janela2.periodo", n, G);
      check_saidas("janela2", 10, 10, 0, 0, 0, 1);

      // Table of input rates. The window in which the rate changes is
      // dropped, and the next full window is checked.
      for (int i = 0; i < 6; i++) begin
         periodo = tab[i].periodo;
         esperar_valido($sformatf("tab%0d.descarte", i), n);
         esperar_valido($sformatf("tab%0d", i), n);
         check($sformatf("tab%0d.periodo", i), n, G);
         check_saidas($sformatf("tab%0d", i), tab[i].freq_a, tab[i].freq_b,
                      int'(tab[i].est_a), int'(tab[i].est_b), int'(tab[i].sem), 1);
      end

      // Abort 50 cycles into a window, then re-enable 20 cycles later.
      periodo = 10;
      esperar_valido("abort.descarte", n);
      esperar_valido("abort.base", n);
      check_saidas("abort.base", 10, 10, 0, 0, 0, 1);
      pulsos = 0;
      repeat (50) begin tick(); pulsos += int'(va); end
      habilita = 1'b0;
      repeat (20) begin tick(); pulsos += int'(va); end
      check("abort.sem_valido", pulsos, 0);
      check_saidas("abort.mantem", 10, 10, 0, 0, 0, 0);
      habilita = 1'b1;
      esperar_valido("abort.reinicio", n);
      check("abort.reinicio.latencia", n, G + 1);
      check_saidas("abort.reinicio", 10, 10, 0, 0, 0, 1);

      // Abort landing on the final window cycle: the abort wins.
      pulsos = 0;
      repeat (G - 1) begin tick(); pulsos += int'(va); end
      habilita = 1'b0;
      tick();
      pulsos += int'(va);
      check("abort_final.sem_valido", pulsos, 0);
      check_saidas("abort_final.mantem", 10, 10, 0, 0, 0, 0);
      tick();

      // Reset pulse mid-window. It is applied while the input is in its low
      // phase, so restarting the synchroniser adds no false edge.
      habilita = 1'b1;
      esperar_valido("reset_meio.base", n);
      check_saidas("reset_meio.base", 10, 10, 0, 0, 0, 1);
      repeat (30) tick();
      n = 0;
      while (!(sinal_in == 1'b0 && fase == periodo / 2 + 1) && n < 20) begin
         tick();
         n++;
      end
      reset = 1'b0;
      tick();
      check_saidas("reset_meio.zerado", 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      esperar_valido("reset_meio.nova", n);
      check("reset_meio.latencia", n, G + 1);
      check_saidas("reset_meio.nova", 10, 10, 0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, erros);
      $finish;
   end

endmodule

// File: doc/medidor_frequencia.md
# medidor_frequencia

Frequency meter for an external slow square wave (e.g. a divided clock, button or sensor line) measured against the 50 MHz board clock. It resynchronises the asynchronous input, counts its rising edges over a fixed gate window of GATE_CYCLES clock cycles (1 s by default), and publishes the count with a one-cycle valid strobe. The result sits between the input pins and the display/decoder logic, which reads `frequencia` directly in Hz.

## Interface
- GATE_CYCLES, 50000000: gate window length in clock_50 cycles; ≥ 2
- WIDTH, 26: width of the edge counter and of `frequencia`
- clock_50  input  1  system clock, 50 MHz, all logic on rising edge
- reset  input  1  synchronous, active-low reset, sampled on clock_50 rising edge
- habilita  input  1  1 = run back-to-back measurement windows; 0 = stop/abort
- sinal_in  input  1  asynchronous signal under measurement
- frequencia  output  WIDTH  edge count of the last completed window (saturated)
- valido  output  1  one-cycle pulse: new `frequencia`/flags just loaded
- estouro  output  1  last window's count saturated at 2^WIDTH-1
- sem_sinal  output  1  last window saw zero rising edges

## Operation
- Input path: 2-FF synchroniser (s1, s2) plus one history FF (s3); edge pulse = s2 & ~s3. All three cleared by reset; a `sinal_in` already high when reset is released therefore produces one edge pulse.
- Gate counter: internal, wide enough to hold GATE_CYCLES-1, independent of WIDTH.
- Edge counter: WIDTH bits, increments on each edge pulse, saturates at 2^WIDTH-1; internal sticky `sat` flag sets on any increment attempt at max.
- FSM states:
  - PARADO: gate counter, edge counter, `sat` held at 0. `habilita`=1 → JANELA.
  - JANELA: gate counter +1 per cycle; edges counted. On the final window cycle (gate counter == GATE_CYCLES-1): load `frequencia` ← edge count including any edge pulse in that same cycle, `estouro` ← `sat` (or saturating in that cycle), `sem_sinal` ← (final count == 0); clear gate counter, edge counter, `sat`; stay in JANELA. `habilita`=0 in any cycle → PARADO, window discarded.
- No dead time between consecutive windows: an edge pulse in the first cycle of a new window is counted in that window.
- `frequencia`, `estouro`, `sem_sinal` change only on window completion or reset; they hold across aborts and PARADO.
- `valido` registered: high exactly the cycle after the final window cycle, same cycle the new outputs become visible.
- Reset (reset=0 at a rising edge): all state to reset values on that edge regardless of state; takes priority over window completion in the same cycle.

## Timing
- Reset values: `frequencia`=0, `valido`=0, `estouro`=0, `sem_sinal`=0, FSM=PARADO, synchroniser FFs=0.
- `habilita` sampled 1 at edge t (in PARADO) → window covers cycles t+1 … t+GATE_CYCLES; `valido`/new result at t+GATE_CYCLES+1; subsequent results every GATE_CYCLES cycles.
- `sinal_in` rising edge first sampled high by s1 at edge k → edge pulse active in cycle after edge k+1 (2-cycle latency); it belongs to whichever window contains that cycle.
- Guaranteed detection requires high and low phases each ≥ 2 clock periods; shorter pulses may be missed. Max countable rate: one edge per 2 cycles.
- `habilita` dropping on the final window cycle: abort wins, no `valido`.

## Test plan
- Reset: hold reset=0 for 3 cycles with `sinal_in` toggling, `habilita`=1 → all outputs 0, no `valido`, through 2 cycles after release.
- GATE_CYCLES=100, WIDTH=8, `sinal_in` period 10 (5 high/5 low) running before `habilita`↑ → `valido` every 100 cycles, first at 101 cycles after `habilita` sampled, `frequencia`=10, `estouro`=0, `sem_sinal`=0 each window.
- Same params, `sinal_in` held 0 → `frequencia`=0, `sem_sinal`=1, `valido` still pulses every 100 cycles.
- GATE_CYCLES=100, WIDTH=4, `sinal_in` period 4 (25 edges/window) → `frequencia`=15, `estouro`=1; switch to period 10 → next window `frequencia`=10, `estouro`=0.
- After one result of 10, drop `habilita` 50 cycles into window, raise after 20 cycles → no `valido` for aborted window, `frequencia` stays 10; next `valido` 101 cycles after re-enable sample.
- Assert reset for 1 cycle mid-window with `frequencia`=10 → next edge all outputs 0, FSM PARADO; with `habilita`=1 a new full 100-cycle window follows and reports 10.
